// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared constants and helpers for the arbitrating multiplexer
package arb_mux_pkg;
  localparam int MAX_CHANNELS = 16;
  function automatic int chan_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, optionally restricted to a locked channel
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CW       = chan_idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [CW-1:0]       ptr_i,
  input  logic                lock_en_i,
  input  logic [CW-1:0]       lock_idx_i,
  output logic                grant_valid_o,
  output logic [CW-1:0]       grant_idx_o
);
  logic [CHANNELS-1:0] elig;
  assign elig = lock_en_i ? req_i & (CHANNELS'(1) << lock_idx_i) : req_i;
  // scan offsets from farthest to nearest so the channel closest to ptr wins
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      int k;
      k = int'(ptr_i) + i;
      k = (k >= CHANNELS) ? k - CHANNELS : k;
      if (elig[k]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = CW'(k);
      end
    end
  end
endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel registered mux with round-robin arbitration and optional packet lock
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CHANNELS    = 4,
  parameter int PACKET_MODE = 0,
  localparam int CW         = chan_idx_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [CW-1:0]             out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [CW-1:0]    ptr_q, ptr_d, lock_idx_q, lock_idx_d, chan_q, chan_d, grant_idx;
  logic             lock_en_q, lock_en_d, valid_q, valid_d, last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d, sel_data;
  logic             grant_valid, load_en, take, sel_last;
  rr_arbiter #(.CHANNELS(CHANNELS), .CW(CW)) u_arb (
    .req_i        (in_valid),
    .ptr_i        (ptr_q),
    .lock_en_i    (lock_en_q),
    .lock_idx_i   (lock_idx_q),
    .grant_valid_o(grant_valid),
    .grant_idx_o  (grant_idx)
  );
  assign load_en  = !valid_q | out_ready;
  assign take     = load_en & grant_valid & !reset;
  assign sel_data = in_data[grant_idx*WIDTH +: WIDTH];
  assign sel_last = in_last[grant_idx];
  assign in_ready = take ? CHANNELS'(1) << grant_idx : '0;
  // next state: load on accept, drain on consumer accept, hold otherwise
  always_comb begin
    valid_d    = take | (valid_q & !out_ready);
    data_d     = take ? sel_data : data_q;
    last_d     = take ? sel_last : last_q;
    chan_d     = take ? grant_idx : chan_q;
    ptr_d      = !take ? ptr_q : (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    lock_en_d  = (PACKET_MODE != 0 && take) ? !sel_last : lock_en_q;
    lock_idx_d = take ? grant_idx : lock_idx_q;
  end
  // output register, round-robin pointer and packet lock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      chan_q     <= '0;
      ptr_q      <= '0;
      lock_en_q  <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      chan_q     <= chan_d;
      ptr_q      <= ptr_d;
      lock_en_q  <= lock_en_d;
      lock_idx_q <= lock_idx_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_chan  = chan_q;
endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: scoreboard bench over round-robin, packet-lock and 3-channel instances
module tb_arb_mux_n;
  typedef struct {
    logic [31:0] chan;
    logic [31:0] data;
  } beat_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [127:0] a_data = '0, b_data = '0;
  logic [95:0]  c_data = '0;
  logic [3:0]   a_valid = '0, a_last = '0, a_ready, b_valid = '0, b_last = '0, b_ready;
  logic [2:0]   c_valid = '0, c_last = '0, c_ready;
  logic [31:0]  a_odata, b_odata, c_odata;
  logic [1:0]   a_ochan, b_ochan, c_ochan;
  logic         a_olast, b_olast, c_olast, a_ovalid, b_ovalid, c_ovalid;
  logic         a_oready = 1'b1, b_oready = 1'b1, c_oready = 1'b1;
  int n_cmp = 0, n_err = 0;
  beat_t qa[$], qb[$], qc[$];
  beat_t ea, eb, ec;
  always #5 clk = ~clk;
  arb_mux_n #(.WIDTH(32), .CHANNELS(4), .PACKET_MODE(0)) u_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
    .in_ready(a_ready), .out_data(a_odata), .out_last(a_olast), .out_chan(a_ochan),
    .out_valid(a_ovalid), .out_ready(a_oready)
  );
  arb_mux_n #(.WIDTH(32), .CHANNELS(4), .PACKET_MODE(1)) u_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
    .in_ready(b_ready), .out_data(b_odata), .out_last(b_olast), .out_chan(b_ochan),
    .out_valid(b_ovalid), .out_ready(b_oready)
  );
  arb_mux_n #(.WIDTH(32), .CHANNELS(3), .PACKET_MODE(0)) u_c (
    .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_last(c_last),
    .in_ready(c_ready), .out_data(c_odata), .out_last(c_olast), .out_chan(c_ochan),
    .out_valid(c_ovalid), .out_ready(c_oready)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // scoreboards: compare each beat as the consumer takes it
  always @(negedge clk) if (!reset && a_ovalid && a_oready) begin
    if (qa.size() == 0) chk("a_unexpected", 32'(qa.size()), 1);
    else begin
      ea = qa.pop_front();
      chk("a_chan", 32'(a_ochan), ea.chan);
      chk("a_data", a_odata, ea.data);
    end
  end
  always @(negedge clk) if (!reset && b_ovalid && b_oready) begin
    if (qb.size() == 0) chk("b_unexpected", 32'(qb.size()), 1);
    else begin
      eb = qb.pop_front();
      chk("b_chan", 32'(b_ochan), eb.chan);
      chk("b_data", b_odata, eb.data);
    end
  end
  always @(negedge clk) if (!reset && c_ovalid && c_oready) begin
    chk("c_chan_range", 32'(c_ochan < 2'd3), 1);
    if (qc.size() == 0) chk("c_unexpected", 32'(qc.size()), 1);
    else begin
      ec = qc.pop_front();
      chk("c_chan", 32'(c_ochan), ec.chan);
      chk("c_data", c_odata, ec.data);
    end
  end
  initial begin
    a_valid = 4'hF;
    for (int c = 0; c < 4; c++) a_data[c*32 +: 32] = 32'hA0 + 32'(c);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(a_ovalid), 0);
    chk("rst_data", a_odata, 0);
    chk("rst_chan", 32'(a_ochan), 0);
    chk("rst_ready", 32'(a_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    a_valid = 4'h0;
    // round robin, one beat per cycle
    @(posedge clk); #1;
    a_valid = 4'hF;
    for (int i = 0; i < 5; i++) qa.push_back('{32'(i % 4), 32'hA0 + 32'(i % 4)});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 4) a_valid = 4'h0;
      @(negedge clk);
      chk("a_tput", 32'(a_ovalid), 1);
    end
    @(posedge clk);
    @(negedge clk);
    chk("a_drained", 32'(a_ovalid), 0);
    // backpressure on a beat from channel 2
    @(posedge clk); #1;
    a_valid = 4'b0100;
    a_data[64 +: 32] = 32'hDEAD;
    qa.push_back('{2, 32'hDEAD});
    @(posedge clk); #1;
    a_oready = 1'b0;
    a_data[64 +: 32] = 32'hBEEF;
    qa.push_back('{2, 32'hBEEF});
    repeat (3) begin
      @(negedge clk);
      chk("bp_data", a_odata, 32'hDEAD);
      chk("bp_chan", 32'(a_ochan), 2);
      chk("bp_ready", 32'(a_ready), 0);
      @(posedge clk);
    end
    #1 a_oready = 1'b1;
    @(negedge clk);
    chk("bp_ready_resume", 32'(a_ready), 32'b0100);
    @(posedge clk); #1;
    a_valid = 4'h0;
    @(negedge clk);
    chk("bp_next", a_odata, 32'hBEEF);
    // packet lock: move ptr to 1, then channel 1 sends 3 beats with a gap
    @(posedge clk); #1;
    b_valid = 4'b0001;
    b_data[0 +: 32] = 32'h100;
    b_last = 4'b0001;
    qb.push_back('{0, 32'h100});
    @(posedge clk); #1;
    b_valid = 4'b0011;
    b_data[0 +: 32] = 32'h200;
    b_data[32 +: 32] = 32'h11;
    qb.push_back('{1, 32'h11});
    @(posedge clk); #1;
    b_data[32 +: 32] = 32'h12;
    qb.push_back('{1, 32'h12});
    @(posedge clk); #1;
    b_valid = 4'b0001;
    @(negedge clk);
    chk("lock_ready0", 32'(b_ready), 0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("lock_idle", 32'(b_ovalid), 0);
      chk("lock_ready", 32'(b_ready), 0);
    end
    @(posedge clk); #1;
    b_valid = 4'b0011;
    b_data[32 +: 32] = 32'h13;
    b_last = 4'b0011;
    qb.push_back('{1, 32'h13});
    qb.push_back('{0, 32'h200});
    @(posedge clk); #1;
    b_valid = 4'b0001;
    @(posedge clk); #1;
    b_valid = 4'b0000;
    @(posedge clk);
    // three channels: wrap from 2 to 0, then 1
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) c_data[c*32 +: 32] = 32'hC0 + 32'(c);
    c_valid = 3'b100;
    qc.push_back('{2, 32'hC2});
    qc.push_back('{0, 32'hC0});
    qc.push_back('{1, 32'hC1});
    @(posedge clk); #1;
    c_valid = 3'b111;
    repeat (2) @(posedge clk);
    #1 c_valid = 3'b000;
    @(posedge clk);
    // asynchronous reset while locked on channel 3 with a held beat
    @(posedge clk); #1;
    b_valid = 4'b1000;
    b_last = 4'b0000;
    b_data[96 +: 32] = 32'h33;
    b_oready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 32'(b_ovalid), 1);
    chk("pre_rst_chan", 32'(b_ochan), 3);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(b_ovalid), 0);
    chk("arst_ready", 32'(b_ready), 0);
    chk("arst_data", b_odata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    b_valid = 4'hF;
    b_oready = 1'b1;
    b_data[0 +: 32] = 32'h40;
    qb.push_back('{0, 32'h40});
    @(posedge clk); #1;
    b_valid = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("qa_empty", 32'(qa.size()), 0);
    chk("qb_empty", 32'(qb.size()), 0);
    chk("qc_empty", 32'(qc.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
